// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-channel TDM serializer/deserializer pair.
package tdm_pkg;

   localparam int NCH = 4;

   typedef logic [1:0] ch_idx_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/tdm_out_slot.sv
// Output frame slot: 4-word register bank with valid/ready handshake.
module tdm_out_slot
   import tdm_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       load,
   input  logic [NCH-1:0][WIDTH-1:0]  frame,
   input  logic                       out_ready,
   output logic [NCH-1:0][WIDTH-1:0]  slot,
   output logic                       out_valid,
   output logic                       overrun
);

   logic slot_free;

   assign slot_free = !out_valid || out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         slot      <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (load) begin
            // A frame that cannot be placed is dropped, never merged.
            if (slot_free) begin
               slot      <= frame;
               out_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/tdm_demux_14.sv
// 1:4 TDM demux: sequences channel words into a frame and hands it to the slot.
module tdm_demux_14
   import tdm_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             in_valid,
   input  logic             frame_start,
   output logic [WIDTH-1:0] out0,
   output logic [WIDTH-1:0] out1,
   output logic [WIDTH-1:0] out2,
   output logic [WIDTH-1:0] out3,
   output logic             out_valid,
   input  logic             out_ready,
   output ch_idx_t          sel,
   output logic             sync_err,
   output logic             overrun
);

   state_t                      state;
   state_t                      state_nxt;
   ch_idx_t                     sel_nxt;
   logic [NCH-2:0][WIDTH-1:0]   shadow;
   logic [NCH-2:0][WIDTH-1:0]   shadow_nxt;
   logic                        err_nxt;
   logic                        complete;
   logic [NCH-1:0][WIDTH-1:0]   frame;
   logic [NCH-1:0][WIDTH-1:0]   slot;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         sel      <= '0;
         shadow   <= '0;
         sync_err <= 1'b0;
      end else begin
         state    <= state_nxt;
         sel      <= sel_nxt;
         shadow   <= shadow_nxt;
         sync_err <= err_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      sel_nxt    = sel;
      shadow_nxt = shadow;
      err_nxt    = 1'b0;
      complete   = 1'b0;
      if (in_valid) begin
         unique case (state)
            IDLE: begin
               if (frame_start) begin
                  shadow_nxt[0] = data_in;
                  sel_nxt       = 2'd1;
                  state_nxt     = RUN;
               end
            end
            RUN: begin
               // A new frame_start restarts the frame from channel 0.
               if (frame_start) begin
                  err_nxt       = 1'b1;
                  shadow_nxt[0] = data_in;
                  sel_nxt       = 2'd1;
               end else if (sel == 2'd3) begin
                  complete  = 1'b1;
                  sel_nxt   = 2'd0;
                  state_nxt = IDLE;
               end else begin
                  if (sel == 2'd1) shadow_nxt[1] = data_in;
                  if (sel == 2'd2) shadow_nxt[2] = data_in;
                  sel_nxt = sel + 2'd1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign frame = {data_in, shadow[2], shadow[1], shadow[0]};

   tdm_out_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (complete),
      .frame     (frame),
      .out_ready (out_ready),
      .slot      (slot),
      .out_valid (out_valid),
      .overrun   (overrun)
   );

   assign out0 = slot[0];
   assign out1 = slot[1];
   assign out2 = slot[2];
   assign out3 = slot[3];

endmodule
